// File: rtl/mau_controller.sv
// Memory access unit controller: lets a host read/write the CPU's IM, DM and
// RF while the CPU is held in reset, and runs the CPU until halt, timeout or
// a host stop, reporting the run's cycle count.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/ready/op/addr/data host command channel
//   rsp_valid/ready/status/data  host response channel
//   mau_address/write_data/wren_{im,dm,rf}  memory access per target
//   mau_read_data_{im,dm,rf}     memory read data per target
//   alive                        CPU run enable (0 = CPU in reset)
//   halt                         CPU reached its halt instruction
module mau_controller #(
  parameter logic [31:0] CYCLE_LIMIT  = 32'h00FF_FFFF,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_data,
  output logic [31:0] mau_address_im,
  output logic [31:0] mau_address_dm,
  output logic [31:0] mau_address_rf,
  output logic [31:0] mau_write_data_im,
  output logic [31:0] mau_write_data_dm,
  output logic [31:0] mau_write_data_rf,
  output logic        mau_wren_im,
  output logic        mau_wren_dm,
  output logic        mau_wren_rf,
  input  logic [31:0] mau_read_data_im,
  input  logic [31:0] mau_read_data_dm,
  input  logic [31:0] mau_read_data_rf,
  output logic        alive,
  input  logic        halt
);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_HALTED  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;
  localparam logic [2:0] OP_RUN     = 3'd6;

  typedef enum logic [2:0] {IDLE, WRITE, READ_WAIT, RESP, RUN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d, cnt_inc;
  logic [2:0]        wait_q, wait_d;
  logic [1:0]        tgt_q, tgt_d, tgt_c;
  logic              alive_q, alive_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              err_q, err_d;        // current response is an ERROR answer during a run
  logic              pend_q, pend_d;      // run ended while the ERROR answer was still pending
  logic [1:0]        pend_status_q, pend_status_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic [2:0][31:0]  addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]        wren_q, wren_d;
  logic              accept, ev;
  logic [1:0]        ev_status;
  logic [31:0]       ev_data, rdata_sel;

  assign accept  = cmd_valid && cmd_ready_q;
  assign cnt_inc = cnt_q + 32'd1;

  // Target index: 0=IM, 1=DM, 2=RF for both write and read opcodes
  always_comb begin
    tgt_c = cmd_op[1:0];
    if (cmd_op >= 3'd3) tgt_c = 2'(cmd_op - 3'd3);
  end

  always_comb begin
    case (tgt_q)
      2'd0:    rdata_sel = mau_read_data_im;
      2'd1:    rdata_sel = mau_read_data_dm;
      default: rdata_sel = mau_read_data_rf;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    tgt_d         = tgt_q;
    alive_d       = alive_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_status_d  = rsp_status_q;
    rsp_data_d    = rsp_data_q;
    err_d         = err_q;
    pend_d        = pend_q;
    pend_status_d = pend_status_q;
    pend_data_d   = pend_data_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wren_d        = '0;
    ev            = 1'b0;
    ev_status     = ST_OK;
    ev_data       = '0;

    // Run-ending events, priority halt > timeout > stop
    if (alive_q) begin
      cnt_d = cnt_inc;
      if (halt) begin
        ev = 1'b1; ev_status = ST_HALTED; ev_data = cnt_q;
      end else if (cnt_inc == CYCLE_LIMIT) begin
        ev = 1'b1; ev_status = ST_TIMEOUT; ev_data = CYCLE_LIMIT;
      end else if (state_q == RUN && accept && cmd_op == 3'd7) begin
        ev = 1'b1; ev_status = ST_OK; ev_data = cnt_q;
      end
      if (ev) alive_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_op <= 3'd2) begin
            state_d = WRITE;
            for (int i = 0; i < 3; i++) begin
              if (tgt_c == 2'(i)) begin
                wren_d[i]  = 1'b1;
                addr_d[i]  = cmd_addr;
                wdata_d[i] = cmd_data;
              end
            end
          end else if (cmd_op <= 3'd5) begin
            state_d = READ_WAIT;
            wait_d  = '0;
            tgt_d   = tgt_c;
            for (int i = 0; i < 3; i++) begin
              if (tgt_c == 2'(i)) addr_d[i] = cmd_addr;
            end
          end else if (cmd_op == OP_RUN) begin
            state_d = RUN;
            cnt_d   = '0;
            alive_d = 1'b1;
          end else begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_OK;
            rsp_data_d   = '0;
            err_d        = 1'b0;
          end
        end
      end
      WRITE: begin
        state_d      = RESP;
        rsp_valid_d  = 1'b1;
        rsp_status_d = ST_OK;
        rsp_data_d   = '0;
        err_d        = 1'b0;
      end
      READ_WAIT: begin
        if (wait_q == 3'(READ_LATENCY - 1)) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_OK;
          rsp_data_d   = rdata_sel;
          err_d        = 1'b0;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      RUN: begin
        if (ev) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ev_status;
          rsp_data_d   = ev_data;
          err_d        = 1'b0;
        end else if (accept) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_ERROR;
          rsp_data_d   = '0;
          err_d        = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          err_d       = 1'b0;
          if (!err_q) begin
            state_d = IDLE;
          end else if (pend_q) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = pend_status_q;
            rsp_data_d   = pend_data_q;
            pend_d       = 1'b0;
          end else if (ev) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = ev_status;
            rsp_data_d   = ev_data;
          end else begin
            state_d = RUN;
          end
        end else if (ev) begin
          pend_d        = 1'b1;
          pend_status_d = ev_status;
          pend_data_d   = ev_data;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE) || (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wait_q        <= '0;
      tgt_q         <= '0;
      alive_q       <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= '0;
      rsp_data_q    <= '0;
      err_q         <= 1'b0;
      pend_q        <= 1'b0;
      pend_status_q <= '0;
      pend_data_q   <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wren_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wait_q        <= wait_d;
      tgt_q         <= tgt_d;
      alive_q       <= alive_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_data_q    <= rsp_data_d;
      err_q         <= err_d;
      pend_q        <= pend_d;
      pend_status_q <= pend_status_d;
      pend_data_q   <= pend_data_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wren_q        <= wren_d;
    end
  end

  assign cmd_ready         = cmd_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_status        = rsp_status_q;
  assign rsp_data          = rsp_data_q;
  assign alive             = alive_q;
  assign mau_address_im    = addr_q[0];
  assign mau_address_dm    = addr_q[1];
  assign mau_address_rf    = addr_q[2];
  assign mau_write_data_im = wdata_q[0];
  assign mau_write_data_dm = wdata_q[1];
  assign mau_write_data_rf = wdata_q[2];
  assign mau_wren_im       = wren_q[0];
  assign mau_wren_dm       = wren_q[1];
  assign mau_wren_rf       = wren_q[2];

endmodule

// File: tb/tb_mau_controller.sv
// Self-checking bench for mau_controller: scoreboard of expected responses,
// one task per scenario, memory models with a strict read-latency window.
module tb_mau_controller;

  localparam int unsigned LAT   = 2;
  localparam logic [31:0] LIMIT = 32'd150;
  localparam logic [1:0]  OK = 2'd0, HALTED = 2'd1, TIMEOUT = 2'd2, ERROR = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;
  logic [31:0] mau_address_im, mau_address_dm, mau_address_rf;
  logic [31:0] mau_write_data_im, mau_write_data_dm, mau_write_data_rf;
  logic        mau_wren_im, mau_wren_dm, mau_wren_rf;
  logic [31:0] mau_read_data_im, mau_read_data_dm, mau_read_data_rf;
  logic        alive;
  logic        halt = 1'b0;

  mau_controller #(.CYCLE_LIMIT(LIMIT), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_data(rsp_data),
    .mau_address_im(mau_address_im), .mau_address_dm(mau_address_dm),
    .mau_address_rf(mau_address_rf),
    .mau_write_data_im(mau_write_data_im), .mau_write_data_dm(mau_write_data_dm),
    .mau_write_data_rf(mau_write_data_rf),
    .mau_wren_im(mau_wren_im), .mau_wren_dm(mau_wren_dm), .mau_wren_rf(mau_wren_rf),
    .mau_read_data_im(mau_read_data_im), .mau_read_data_dm(mau_read_data_dm),
    .mau_read_data_rf(mau_read_data_rf),
    .alive(alive), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   age = 99;

  // Cycles since the last accepted command; read data is only valid at age LAT-1
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) age <= 99;
    else if (cmd_valid && cmd_ready) age <= 0;
    else if (age < 99) age <= age + 1;
  end

  function automatic logic [31:0] im_model(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction
  function automatic logic [31:0] dm_model(input logic [31:0] a);
    return (a == 32'h10) ? 32'h1234_5678 : ~a;
  endfunction
  function automatic logic [31:0] rf_model(input logic [31:0] a);
    return a + 32'h1000;
  endfunction

  assign mau_read_data_im = (age == int'(LAT) - 1) ? im_model(mau_address_im) : 32'hBAD0_BAD0;
  assign mau_read_data_dm = (age == int'(LAT) - 1) ? dm_model(mau_address_dm) : 32'hBAD0_BAD0;
  assign mau_read_data_rf = (age == int'(LAT) - 1) ? rf_model(mau_address_rf) : 32'hBAD0_BAD0;

  // Present a command at the current falling edge; returns at the falling edge after acceptance
  task automatic send_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                          output int acc);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept op=%0d: cmd_ready=%b required 1", op, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; lat counts falling edges from the call
  task automatic wait_rsp(output bit got, output int lat, output logic [1:0] st,
                          output logic [31:0] d, output logic alv);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    got = (rsp_valid === 1'b1);
    st  = rsp_status;
    d   = rsp_data;
    alv = alive;
    if (got && rsp_ready) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, alive, mau_wren_im, mau_wren_dm, mau_wren_rf, rsp_status} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b valid=%b alive=%b wren=%b%b%b status=%0d required all 0",
               cmd_ready, rsp_valid, alive, mau_wren_rf, mau_wren_dm, mau_wren_im, rsp_status);
    end
    checks++;
    if ((rsp_data | mau_address_im | mau_address_dm | mau_address_rf |
         mau_write_data_im | mau_write_data_dm | mau_write_data_rf) !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: data/address OR=%h required 0", rsp_data | mau_address_im |
               mau_address_dm | mau_address_rf | mau_write_data_im | mau_write_data_dm | mau_write_data_rf);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write;
    exp_t e; int acc; bit got; int lat; logic [1:0] st; logic [31:0] d; logic alv;
    logic [31:0] a, wd, sa, sd;
    for (int t = 0; t < 3; t++) begin
      a  = (t == 0) ? 32'h8 : 32'(256 * t + 3);
      wd = (t == 0) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(t));
      e.st = OK; e.d = 32'd0; sb.push_back(e);
      send_cmd(3'(t), a, wd, acc);
      sa = (t == 0) ? mau_address_im : (t == 1) ? mau_address_dm : mau_address_rf;
      sd = (t == 0) ? mau_write_data_im : (t == 1) ? mau_write_data_dm : mau_write_data_rf;
      checks++;
      if ({mau_wren_rf, mau_wren_dm, mau_wren_im} !== 3'(1 << t)) begin
        errors++;
        $display("FAIL write_wren t=%0d: wren=%b%b%b required %b", t,
                 mau_wren_rf, mau_wren_dm, mau_wren_im, 3'(1 << t));
      end
      checks++;
      if (sa !== a || sd !== wd) begin
        errors++;
        $display("FAIL write_addr t=%0d: addr=%h data=%h required %h %h", t, sa, sd, a, wd);
      end
      @(negedge clk);
      checks++;
      if ({mau_wren_rf, mau_wren_dm, mau_wren_im} !== 3'b000 || rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL write_pulse_latency t=%0d: wren=%b%b%b rsp_valid=%b required 000 1", t,
                 mau_wren_rf, mau_wren_dm, mau_wren_im, rsp_valid);
      end
      wait_rsp(got, lat, st, d, alv);
      e = sb.pop_front();
      checks++;
      if (!got || st !== e.st || d !== e.d) begin
        errors++;
        $display("FAIL write_rsp t=%0d: got=%0d status=%0d data=%h required %0d %h",
                 t, got, st, d, e.st, e.d);
      end
    end
    checks++;
    if (mau_address_im !== 32'h8) begin
      errors++;
      $display("FAIL addr_hold: mau_address_im=%h required 00000008", mau_address_im);
    end
  endtask

  task automatic test_read;
    exp_t e; int acc; bit got; int lat; logic [1:0] st; logic [31:0] d; logic alv;
    logic [31:0] a;
    for (int t = 0; t < 3; t++) begin
      a = (t == 0) ? 32'h40 : (t == 1) ? 32'h10 : 32'h7;
      e.st = OK;
      e.d  = (t == 0) ? im_model(a) : (t == 1) ? dm_model(a) : rf_model(a);
      sb.push_back(e);
      send_cmd(3'(3 + t), a, 32'hFFFF_FFFF, acc);
      wait_rsp(got, lat, st, d, alv);
      e = sb.pop_front();
      checks++;
      if (!got || lat != int'(LAT) || st !== e.st || d !== e.d) begin
        errors++;
        $display("FAIL read_rsp t=%0d: got=%0d lat=%0d status=%0d data=%h required lat %0d %0d %h",
                 t, got, lat + 1, st, d, LAT + 1, e.st, e.d);
      end
    end
  endtask

  task automatic test_backpressure;
    exp_t e; int acc; bit got; int lat; logic [1:0] st; logic [31:0] d; logic alv;
    bit bad;
    rsp_ready = 1'b0;
    e.st = OK; e.d = dm_model(32'h20); sb.push_back(e);
    send_cmd(3'd4, 32'h20, 32'd0, acc);
    wait_rsp(got, lat, st, d, alv);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_status !== st || rsp_data !== d || cmd_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rsp_hold: valid=%b ready=%b data=%h required 1 0 %h", rsp_valid, cmd_ready, rsp_data, d);
    end
    e = sb.pop_front();
    checks++;
    if (!got || st !== e.st || d !== e.d) begin
      errors++;
      $display("FAIL rsp_hold_value: status=%0d data=%h required %0d %h", st, d, e.st, e.d);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_release: valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
    end
    // stop while idle answers OK with zero data
    e.st = OK; e.d = 32'd0; sb.push_back(e);
    send_cmd(3'd7, 32'd0, 32'd0, acc);
    wait_rsp(got, lat, st, d, alv);
    e = sb.pop_front();
    checks++;
    if (!got || st !== e.st || d !== e.d || alv !== 1'b0) begin
      errors++;
      $display("FAIL idle_stop: status=%0d data=%h alive=%b required %0d %h 0", st, d, alv, e.st, e.d);
    end
  endtask

  task automatic test_run_halt;
    exp_t e; int acc; bit got; int lat; logic [1:0] st; logic [31:0] d; logic alv;
    bit bad;
    send_cmd(3'd6, 32'd0, 32'd0, acc);
    checks++;
    if (alive !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL run_start: alive=%b rsp_valid=%b required 1 0", alive, rsp_valid);
    end
    bad = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (alive !== 1'b1 || {mau_wren_im, mau_wren_dm, mau_wren_rf} !== 3'b000 || rsp_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL run_steady: alive/wren/rsp_valid deviated during run, required alive=1 wren=000 valid=0");
    end
    halt = 1'b1;
    e.st = HALTED; e.d = 32'd100; sb.push_back(e);
    @(negedge clk);
    halt = 1'b0;
    checks++;
    if (alive !== 1'b0) begin
      errors++;
      $display("FAIL halt_alive: alive=%b required 0", alive);
    end
    wait_rsp(got, lat, st, d, alv);
    e = sb.pop_front();
    checks++;
    if (!got || lat != 0 || st !== e.st || d !== e.d) begin
      errors++;
      $display("FAIL halt_rsp: got=%0d lat=%0d status=%0d data=%0d required lat 0 %0d %0d",
               got, lat, st, d, e.st, e.d);
    end
  endtask

  task automatic test_run_timeout;
    exp_t e; int acc; bit got; int lat; logic [1:0] st; logic [31:0] d; logic alv;
    int n;
    send_cmd(3'd6, 32'd0, 32'd0, acc);
    n = 0;
    while (alive === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != int'(LIMIT)) begin
      errors++;
      $display("FAIL timeout_cycles: alive high %0d cycles required %0d", n, LIMIT);
    end
    e.st = TIMEOUT; e.d = LIMIT; sb.push_back(e);
    wait_rsp(got, lat, st, d, alv);
    e = sb.pop_front();
    checks++;
    if (!got || lat != 0 || st !== e.st || d !== e.d) begin
      errors++;
      $display("FAIL timeout_rsp: got=%0d lat=%0d status=%0d data=%0d required lat 0 %0d %0d",
               got, lat, st, d, e.st, e.d);
    end
  endtask

  task automatic test_run_error_stop;
    exp_t e; int s; int t; bit got; int lat; logic [1:0] st; logic [31:0] d; logic alv;
    send_cmd(3'd6, 32'd0, 32'd0, s);
    repeat (5) @(negedge clk);
    e.st = ERROR; e.d = 32'd0; sb.push_back(e);
    send_cmd(3'd2, 32'h4, 32'h5, t);
    checks++;
    if (mau_wren_rf !== 1'b0 || mau_write_data_rf === 32'h5) begin
      errors++;
      $display("FAIL run_write_blocked: wren_rf=%b wdata_rf=%h required 0 and not 00000005",
               mau_wren_rf, mau_write_data_rf);
    end
    wait_rsp(got, lat, st, d, alv);
    e = sb.pop_front();
    checks++;
    if (!got || st !== e.st || d !== e.d || alv !== 1'b1) begin
      errors++;
      $display("FAIL run_error_rsp: status=%0d data=%h alive=%b required %0d %h 1", st, d, alv, e.st, e.d);
    end
    send_cmd(3'd7, 32'd0, 32'd0, t);
    e.st = OK; e.d = 32'(t - (s + 1)); sb.push_back(e);
    wait_rsp(got, lat, st, d, alv);
    e = sb.pop_front();
    checks++;
    if (!got || st !== e.st || d !== e.d || alv !== 1'b0) begin
      errors++;
      $display("FAIL run_stop_rsp: status=%0d data=%0d alive=%b required %0d %0d 0", st, d, alv, e.st, e.d);
    end
  endtask

  task automatic test_priority;
    exp_t e; int s; int t; bit got; int lat; logic [1:0] st; logic [31:0] d; logic alv;
    bit bad;
    send_cmd(3'd6, 32'd0, 32'd0, s);
    repeat (3) @(negedge clk);
    halt = 1'b1;
    send_cmd(3'd7, 32'd0, 32'd0, t);
    halt = 1'b0;
    e.st = HALTED; e.d = 32'(t - (s + 1)); sb.push_back(e);
    wait_rsp(got, lat, st, d, alv);
    e = sb.pop_front();
    checks++;
    if (!got || st !== e.st || d !== e.d) begin
      errors++;
      $display("FAIL halt_vs_stop: status=%0d data=%0d required %0d %0d", st, d, e.st, e.d);
    end
    bad = 1'b0;
    repeat (4) begin
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || alive !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stop_consumed: rsp_valid=%b cmd_ready=%b alive=%b required 0 1 0",
               rsp_valid, cmd_ready, alive);
    end
  endtask

  task automatic test_reset_mid;
    int acc; bit bad;
    rsp_ready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      if (m == 0) send_cmd(3'd4, 32'h10, 32'd0, acc);
      else begin
        send_cmd(3'd6, 32'd0, 32'd0, acc);
        repeat (10) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid, alive, mau_wren_im, mau_wren_dm, mau_wren_rf, rsp_status} !== '0 ||
          (rsp_data | mau_address_dm | mau_address_im | mau_address_rf |
           mau_write_data_im | mau_write_data_dm | mau_write_data_rf) !== 32'd0) begin
        errors++;
        $display("FAIL reset_mid m=%0d: ready=%b valid=%b alive=%b addr_dm=%h required all 0",
                 m, cmd_ready, rsp_valid, alive, mau_address_dm);
      end
      rst = 1'b0;
      @(negedge clk);
      bad = (cmd_ready !== 1'b1);
      repeat (5) begin
        if (rsp_valid !== 1'b0 || alive !== 1'b0) bad = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL reset_mid_after m=%0d: cmd_ready=%b rsp_valid=%b alive=%b required 1 0 0",
                 m, cmd_ready, rsp_valid, alive);
      end
    end
    rsp_ready = 1'b1;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_backpressure;
    test_run_halt;
    test_run_timeout;
    test_run_error_stop;
    test_priority;
    test_reset_mid;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
